// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding controller: tracks in-flight writers over NSTAGE post-RF stages,
// produces per-operand forwarding selects, load-use stall and a saturating stall count.
module hazard_forward_unit #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned NSTAGE   = 3,
  parameter int unsigned ZERO_REG = 31,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [REG_W-1:0]              id_rn,
  input  logic [REG_W-1:0]              id_rm,
  input  logic                          id_rn_used,
  input  logic                          id_rm_used,
  input  logic [REG_W-1:0]              id_rd,
  input  logic                          id_wr,
  input  logic                          id_is_load,
  input  logic                          flush,
  output logic                          stall,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_a_sel,
  output logic [$clog2(NSTAGE+1)-1:0]   fwd_b_sel,
  output logic [$clog2(NSTAGE+1)-1:0]   inflight_cnt,
  output logic [CNT_W-1:0]              stall_cycles
);

  localparam int unsigned SEL_W = $clog2(NSTAGE + 1);
  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  // Entry k-1 models pipeline stage k (1 = EX ... NSTAGE = WB).
  logic [NSTAGE-1:0]             vld_q, vld_d;
  logic [NSTAGE-1:0]             ld_q, ld_d;
  logic [NSTAGE-1:0][REG_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]              stall_cycles_q, stall_cycles_d;

  logic             a_live_c, b_live_c;
  logic             stall_c, push_c;
  logic [SEL_W-1:0] sel_a_c, sel_b_c, inflight_c;

  // Source qualification, load-use detection and youngest-match forwarding.
  always_comb begin
    a_live_c = id_valid & id_rn_used & (id_rn != ZR);
    b_live_c = id_valid & id_rm_used & (id_rm != ZR);
    stall_c  = ~reset & id_valid & ~flush & vld_q[0] & ld_q[0] &
               ((a_live_c & (rd_q[0] == id_rn)) | (b_live_c & (rd_q[0] == id_rm)));
    sel_a_c  = '0;
    sel_b_c  = '0;
    // Walk oldest to youngest so the youngest match is the one that sticks.
    for (int k = int'(NSTAGE); k >= 1; k--) begin
      if (a_live_c && vld_q[k-1] && (rd_q[k-1] == id_rn)) sel_a_c = SEL_W'(k);
      if (b_live_c && vld_q[k-1] && (rd_q[k-1] == id_rm)) sel_b_c = SEL_W'(k);
    end
  end

  // Next state: new writer (or bubble) enters stage 1, older entries advance.
  always_comb begin
    push_c   = id_valid & id_wr & ~stall_c & ~flush & (id_rd != ZR);
    vld_d    = '0;
    ld_d     = '0;
    rd_d     = '0;
    vld_d[0] = push_c;
    ld_d[0]  = push_c & id_is_load;
    rd_d[0]  = push_c ? id_rd : '0;
    for (int k = 1; k < int'(NSTAGE); k++) begin
      vld_d[k] = vld_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
    stall_cycles_d = stall_cycles_q;
    if (stall_c && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  // Population count of live entries.
  always_comb begin
    inflight_c = '0;
    for (int k = 0; k < int'(NSTAGE); k++) begin
      inflight_c = inflight_c + SEL_W'(vld_q[k]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q          <= '0;
      ld_q           <= '0;
      rd_q           <= '0;
      stall_cycles_q <= '0;
    end else begin
      vld_q          <= vld_d;
      ld_q           <= ld_d;
      rd_q           <= rd_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Selects are suppressed while stalling so the bubbled instruction reads nothing stale.
  assign stall        = stall_c;
  assign fwd_a_sel    = (stall_c || reset) ? '0 : sel_a_c;
  assign fwd_b_sel    = (stall_c || reset) ? '0 : sel_b_c;
  assign inflight_cnt = inflight_c;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: vector table plus reset and saturation sequences.
module tb_hazard_forward_unit;

  logic       clk, reset;
  logic       id_valid, id_rn_used, id_rm_used, id_wr, id_is_load, flush;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       stall, stall2;
  logic [1:0] fwd_a_sel, fwd_b_sel, inflight_cnt;
  logic [1:0] fwd_a_sel2, fwd_b_sel2, inflight_cnt2;
  logic [15:0] stall_cycles;
  logic [3:0]  stall_cycles2;

  int asserts = 0;
  int fails   = 0;

  hazard_forward_unit dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .inflight_cnt(inflight_cnt), .stall_cycles(stall_cycles)
  );

  hazard_forward_unit #(.CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rn(id_rn), .id_rm(id_rm),
    .id_rn_used(id_rn_used), .id_rm_used(id_rm_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_is_load(id_is_load), .flush(flush), .stall(stall2), .fwd_a_sel(fwd_a_sel2),
    .fwd_b_sel(fwd_b_sel2), .inflight_cnt(inflight_cnt2), .stall_cycles(stall_cycles2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       rn_used;
    logic       rm_used;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       fl;
    logic       e_stall;
    logic [1:0] e_a;
    logic [1:0] e_b;
    logic [1:0] e_inf;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic v, input int rn, input int rm, input logic ru,
                              input logic mu, input int rd, input logic wr, input logic ld,
                              input logic fl, input logic es, input int ea, input int eb,
                              input int ei, input int ec);
    vec_t r;
    r.valid = v;      r.rn = 5'(rn);    r.rm = 5'(rm);
    r.rn_used = ru;   r.rm_used = mu;   r.rd = 5'(rd);
    r.wr = wr;        r.ld = ld;        r.fl = fl;
    r.e_stall = es;   r.e_a = 2'(ea);   r.e_b = 2'(eb);
    r.e_inf = 2'(ei); r.e_cnt = 16'(ec);
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int rn, input int rm, input logic ru,
                       input logic mu, input int rd, input logic wr, input logic ld,
                       input logic fl);
    id_valid = v;   id_rn = 5'(rn);   id_rm = 5'(rm);
    id_rn_used = ru; id_rm_used = mu; id_rd = 5'(rd);
    id_wr = wr;     id_is_load = ld;  flush = fl;
  endtask

  initial begin
    //             v  rn  rm ru mu rd  wr ld fl | st a  b  inf cnt
    vecs[0]  = mk(1,  2,  3, 1, 1, 1,  1, 0, 0,  0, 0, 0, 0, 0); // ADD X1
    vecs[1]  = mk(1,  1,  2, 1, 1, 5,  1, 0, 0,  0, 1, 0, 1, 0); // SUB X5,X1,X2
    vecs[2]  = mk(1,  0,  0, 1, 1, 2,  1, 0, 0,  0, 0, 0, 2, 0); // ADD X2
    vecs[3]  = mk(1,  1,  5, 1, 1, 2,  1, 0, 0,  0, 3, 2, 3, 0); // ADD X2 (WB/DM fwd)
    vecs[4]  = mk(1,  2,  2, 1, 1, 3,  1, 0, 0,  0, 1, 1, 3, 0); // ORR X3,X2,X2 youngest
    vecs[5]  = mk(1,  9,  3, 1, 0, 3,  1, 1, 0,  0, 0, 0, 3, 0); // LDUR X3, rm unused
    vecs[6]  = mk(1,  3,  0, 1, 1, 4,  1, 0, 0,  1, 0, 0, 3, 0); // load-use stall
    vecs[7]  = mk(1,  3,  0, 1, 1, 4,  1, 0, 0,  0, 2, 0, 2, 1); // retry, fwd from DM
    vecs[8]  = mk(1,  4,  0, 1, 0, 31, 1, 0, 0,  0, 1, 0, 2, 1); // ADD XZR
    vecs[9]  = mk(1, 31, 31, 1, 1, 30, 1, 0, 0,  0, 0, 0, 1, 1); // read X31, BL writer
    vecs[10] = mk(1, 30,  4, 1, 1, 7,  1, 1, 0,  0, 1, 3, 2, 1); // read X30, LDUR X7
    vecs[11] = mk(1,  7,  0, 1, 0, 8,  1, 0, 1,  0, 1, 0, 2, 1); // load-use under flush
    vecs[12] = mk(0, 30,  0, 1, 0, 9,  1, 0, 0,  0, 0, 0, 2, 1); // invalid slot
    vecs[13] = mk(1,  7,  7, 1, 1, 0,  0, 0, 0,  0, 3, 3, 1, 1); // load reaches WB
    vecs[14] = mk(1,  7,  0, 1, 0, 6,  1, 1, 0,  0, 0, 0, 0, 1); // LDUR X6, pipe empty
    vecs[15] = mk(1,  1,  6, 1, 1, 0,  0, 0, 0,  1, 0, 0, 1, 1); // use via source B
    vecs[16] = mk(1,  1,  6, 1, 1, 0,  0, 0, 0,  0, 0, 2, 1, 2);
    vecs[17] = mk(0,  0,  0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 1, 2);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset stall", int'(stall), 0);
    check("reset fwd_a", int'(fwd_a_sel), 0);
    check("reset fwd_b", int'(fwd_b_sel), 0);
    check("reset inflight", int'(inflight_cnt), 0);
    check("reset stall_cycles", int'(stall_cycles), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, int'(vecs[i].rn), int'(vecs[i].rm), vecs[i].rn_used,
            vecs[i].rm_used, int'(vecs[i].rd), vecs[i].wr, vecs[i].ld, vecs[i].fl);
      #2;
      check($sformatf("v%0d stall", i), int'(stall), int'(vecs[i].e_stall));
      check($sformatf("v%0d fwd_a", i), int'(fwd_a_sel), int'(vecs[i].e_a));
      check($sformatf("v%0d fwd_b", i), int'(fwd_b_sel), int'(vecs[i].e_b));
      check($sformatf("v%0d inflight", i), int'(inflight_cnt), int'(vecs[i].e_inf));
      check($sformatf("v%0d stall_cycles", i), int'(stall_cycles), int'(vecs[i].e_cnt));
    end

    // Three writers in flight, then reset asserted between clock edges.
    for (int r = 10; r <= 12; r++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, r, 1, 0, 0);
    end
    @(negedge clk);
    drive(1, 12, 10, 1, 1, 0, 0, 0, 0);
    #1;
    check("pre-reset fwd_a", int'(fwd_a_sel), 1);
    check("pre-reset fwd_b", int'(fwd_b_sel), 3);
    check("pre-reset inflight", int'(inflight_cnt), 3);
    #1 reset = 1'b1;
    #1;
    check("async reset inflight", int'(inflight_cnt), 0);
    check("async reset fwd_a", int'(fwd_a_sel), 0);
    check("async reset fwd_b", int'(fwd_b_sel), 0);
    check("async reset stall_cycles", int'(stall_cycles), 0);
    check("async reset inflight narrow", int'(inflight_cnt2), 0);
    check("async reset fwd_a narrow", int'(fwd_a_sel2), 0);
    check("async reset fwd_b narrow", int'(fwd_b_sel2), 0);
    check("async reset stall_cycles narrow", int'(stall_cycles2), 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 12, 10, 1, 1, 0, 0, 0, 0);
    #2;
    check("post-reset fwd_a", int'(fwd_a_sel), 0);

    // Twenty load-use pairs: wide counter reaches 20, 4-bit counter pins at 15.
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
      @(negedge clk);
      drive(1, 3, 0, 1, 0, 4, 1, 0, 0);
      #2;
      check($sformatf("sat%0d stall", n), int'(stall), 1);
      check($sformatf("sat%0d stall narrow", n), int'(stall2), 1);
      @(negedge clk);
      #2;
      check($sformatf("sat%0d resolved", n), int'(stall), 0);
      check($sformatf("sat%0d fwd_a", n), int'(fwd_a_sel), 2);
    end
    check("stall_cycles wide", int'(stall_cycles), 20);
    check("stall_cycles saturated", int'(stall_cycles2), 15);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
